down_counter_ctl: RTL and testbench
===================================

Name: down_counter_ctl

Overview:
- Loadable down counter that complements the existing 3-bit up counter. It counts from a loaded value toward zero and flags the terminal count.
- Supports one-shot and auto-reload operation, which makes it usable as a timer or tick divider beside the up counter in the lab designs.
- Single clock. Fully synchronous, with no ripple stages.

Parameters:
- WIDTH, 3: counter width in bits.
- RELOAD_DEFAULT, 3'b111: count value after reset, and the reload value until the first load.

Ports:
- clk  input  1  system clock; all logic updates on its rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset).
- load  input  1  capture load_val on this edge.
- load_val  input  WIDTH  value to load, also latched as the reload value.
- en  input  1  count enable.
- auto_reload  input  1  1 = wrap to the reload value at zero; 0 = stop at zero.
- count_out  output  WIDTH  current count.
- tc  output  1  one-cycle pulse on the edge where count goes 1 -> 0.
- busy  output  1  high while in the RUN state.
- done  output  1  high while in the DONE state (one-shot finished).

Behaviour:
- Reset (reset==0 at a clk edge):
  - count_out = RELOAD_DEFAULT and reload register = RELOAD_DEFAULT.
  - tc = 0, busy = 0, done = 0, state = IDLE.
  - Reset overrides every other input, including mid-count.
- States: IDLE, RUN, DONE.
- IDLE:
  - load=1: count <= load_val, reload <= load_val. If load_val != 0, go to RUN; if load_val == 0, go to DONE with no tc pulse.
  - en=1 without load: go to RUN using the current count. If the current count is 0, go to DONE instead.
- RUN, en=1 and count>1: count decrements by 1.
- RUN, en=1 and count==1:
  - count <= 0 and tc = 1 on that edge, registered so it is visible for exactly one cycle.
  - auto_reload=0: go to DONE.
  - auto_reload=1: stay in RUN; the next enabled edge loads reload into count, i.e. 0 -> reload, with no extra tc.
- RUN, en=1 and count==0: only reachable in auto-reload; count <= reload. If reload == 0, go to DONE.
- RUN, en=0: count holds, state holds, tc=0.
- DONE:
  - count holds at 0 and done=1.
  - load=1 behaves as in IDLE.
  - en alone does nothing.
- load has priority over en in every state, including RUN: a mid-count load restarts from load_val and suppresses tc on that edge.
- Arithmetic is WIDTH-bit modulo, but underflow below 0 never occurs; the zero handling above prevents it.
- Latency: count_out, tc, busy and done are all registered. Each changes on the edge after the input that causes it.
- busy == (state==RUN); done == (state==DONE).

Optional Feature:
- Macro: DOWNCNT_PRESCALE_EN.
- When defined:
  - Adds parameter PRESCALE (default 4) and an internal prescale counter of width $clog2(PRESCALE).
  - Decrements happen only on every PRESCALE-th enabled cycle in RUN.
  - The prescaler clears on reset, on load, and on entering RUN.
  - tc still lasts exactly one clk cycle.
- When undefined: the count decrements every enabled cycle, as described above, and no prescaler logic exists.

Decomposition:
- Package down_counter_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - WIDTH default constant;
  - PRESCALE default constant.
- One natural sub-module, downcnt_prescaler: tick generator, instantiated only under DOWNCNT_PRESCALE_EN.
- The counter datapath and FSM stay in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> count_out=7, tc=0, busy=0, done=0.
- One-shot: load 3'd3, auto_reload=0, en=1 -> count 3,2,1,0 on successive edges; tc high only on the 1->0 edge; done=1 afterwards; count holds at 0 for 5 more cycles.
- Auto-reload: load 3'd2, auto_reload=1, en=1 -> count sequence 2,1,0,2,1,0; tc pulses twice, 3 cycles apart; busy stays 1.
- Enable gap and mid-load: count at 5, en=0 for 3 cycles -> holds 5; then load 3'd6 with en=1 at count 1 -> count=6 and no tc on that edge.
- Zero load: load 3'd0 -> DONE next cycle with no tc. Separately, assert reset=0 while count=4 in RUN -> next edge count=7, IDLE, tc=0.
- Prescale (with DOWNCNT_PRESCALE_EN, PRESCALE=4): load 3'd2, en=1 -> count changes every 4 cycles; tc is exactly 1 cycle wide.

Source files
------------

// File: rtl/down_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_pkg
// Brief    : Shared types and defaults for the loadable down counter.
// Revision : 1.0 - initial release
// ============================================================================
package down_counter_pkg;

    localparam int c_WIDTH_DEFAULT    = 3;
    localparam int c_PRESCALE_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : down_counter_pkg
`default_nettype wire

// File: rtl/down_counter_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_ctl_if
// Brief    : Control/status bundle between a controller and the down counter.
// Revision : 1.0 - initial release
// ============================================================================
interface down_counter_ctl_if
    import down_counter_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count_out;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, en, auto_reload,
        input  count_out, tc, busy, done
    );

    modport slave (
        input  load, load_val, en, auto_reload,
        output count_out, tc, busy, done
    );
endinterface : down_counter_ctl_if
`default_nettype wire

// File: rtl/downcnt_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : downcnt_prescaler
// Brief    : Emits a one-cycle tick on every PRESCALE-th enabled cycle.
// Revision : 1.0 - initial release
// ============================================================================
module downcnt_prescaler
    import down_counter_pkg::*;
#(
    parameter int PRESCALE = c_PRESCALE_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clr,
    input  wire logic en,
    output logic      tick
);
    // A prescale of 1 still needs a one-bit counter to stay legal.
    localparam int c_PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0] c_LAST = c_PRE_W'(PRESCALE - 1);

    logic [c_PRE_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == c_LAST);
    assign tick   = en && w_last;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + c_PRE_W'(1);
        end
    end
endmodule : downcnt_prescaler
`default_nettype wire

// File: rtl/down_counter_ctl.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_ctl
// Brief    : Loadable down counter with terminal-count pulse, one-shot and
//            auto-reload modes. Define DOWNCNT_PRESCALE_EN to slow the count
//            by PRESCALE enabled cycles per decrement.
// Revision : 1.0 - initial release
// ============================================================================
module down_counter_ctl
    import down_counter_pkg::*;
#(
    parameter int               WIDTH          = c_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RELOAD_DEFAULT = '1
`ifdef DOWNCNT_PRESCALE_EN
    ,
    parameter int               PRESCALE       = c_PRESCALE_DEFAULT
`endif
) (
    input  wire logic         clk,
    input  wire logic         reset,
    down_counter_ctl_if.slave bus
);
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic             r_tc, w_tc_nxt;
    logic             w_tick;

`ifdef DOWNCNT_PRESCALE_EN
    logic w_pre_clr;
    logic w_pre_en;

    // Restart the prescale phase on any load or any start from IDLE.
    assign w_pre_clr = bus.load || ((r_state == IDLE) && bus.en);
    assign w_pre_en  = bus.en && (r_state == RUN);

    downcnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (w_pre_clr),
        .en    (w_pre_en),
        .tick  (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_count  <= RELOAD_DEFAULT;
            r_reload <= RELOAD_DEFAULT;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;

        if (bus.load) begin
            // Load wins in every state and never produces a terminal pulse.
            w_count_nxt  = bus.load_val;
            w_reload_nxt = bus.load_val;
            w_state_nxt  = (bus.load_val != '0) ? RUN : DONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.en) begin
                        w_state_nxt = (r_count != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (bus.en && w_tick) begin
                        if (r_count > WIDTH'(1)) begin
                            w_count_nxt = r_count - WIDTH'(1);
                        end else if (r_count == WIDTH'(1)) begin
                            w_count_nxt = '0;
                            w_tc_nxt    = 1'b1;
                            if (!bus.auto_reload) begin
                                w_state_nxt = DONE;
                            end
                        end else begin
                            // Zero in RUN means the wrap step of auto-reload.
                            w_count_nxt = r_reload;
                            if (r_reload == '0) begin
                                w_state_nxt = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.count_out = r_count;
    assign bus.tc        = r_tc;
    assign bus.busy      = (r_state == RUN);
    assign bus.done      = (r_state == DONE);
endmodule : down_counter_ctl
`default_nettype wire

// File: tb/tb_down_counter_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_down_counter_ctl
// Brief    : Scoreboard bench for down_counter_ctl with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_down_counter_ctl;

    typedef struct {
        string      name;
        logic [2:0] cnt;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   n_vec;
    int   n_fail;
    bit   stim_done;

    down_counter_ctl_if #(.WIDTH(3)) bus ();

    down_counter_ctl #(
        .WIDTH          (3),
        .RELOAD_DEFAULT (3'b111)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one registered result per clock, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({bus.count_out, bus.tc, bus.busy, bus.done} !==
                    {e.cnt, e.tc, e.busy, e.done}) begin
                    n_fail++;
                    $display("FAIL %s: got count=%0d tc=%0b busy=%0b done=%0b, expected count=%0d tc=%0b busy=%0b done=%0b",
                             e.name, bus.count_out, bus.tc, bus.busy, bus.done,
                             e.cnt, e.tc, e.busy, e.done);
                end
            end
        end
    end

    task automatic step(input string name, input logic rs, input logic ld,
                        input logic [2:0] v, input logic e, input logic ar,
                        input logic [2:0] ec, input logic et,
                        input logic eb, input logic ed);
        exp_t x;
        @(negedge clk);
        reset           = rs;
        bus.load        = ld;
        bus.load_val    = v;
        bus.en          = e;
        bus.auto_reload = ar;
        @(posedge clk);
        x.name = name; x.cnt = ec; x.tc = et; x.busy = eb; x.done = ed;
        exp_q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_fail = 0; stim_done = 0;
        reset = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        bus.en = 1'b0; bus.auto_reload = 1'b0;

        //      name          rs ld val  en ar  cnt tc bs dn
        step("reset0",        0, 0, 3'd0, 0, 0, 3'd7, 0, 0, 0);
        step("reset1",        0, 0, 3'd0, 0, 0, 3'd7, 0, 0, 0);
        step("idle_hold",     1, 0, 3'd0, 0, 0, 3'd7, 0, 0, 0);

`ifdef DOWNCNT_PRESCALE_EN
        step("ps_load",       1, 1, 3'd2, 1, 0, 3'd2, 0, 1, 0);
        step("ps_e1",         1, 0, 3'd0, 1, 0, 3'd2, 0, 1, 0);
        step("ps_e2",         1, 0, 3'd0, 1, 0, 3'd2, 0, 1, 0);
        step("ps_e3",         1, 0, 3'd0, 1, 0, 3'd2, 0, 1, 0);
        step("ps_e4",         1, 0, 3'd0, 1, 0, 3'd1, 0, 1, 0);
        step("ps_e5",         1, 0, 3'd0, 1, 0, 3'd1, 0, 1, 0);
        step("ps_gap",        1, 0, 3'd0, 0, 0, 3'd1, 0, 1, 0);
        step("ps_e6",         1, 0, 3'd0, 1, 0, 3'd1, 0, 1, 0);
        step("ps_e7",         1, 0, 3'd0, 1, 0, 3'd1, 0, 1, 0);
        step("ps_tc",         1, 0, 3'd0, 1, 0, 3'd0, 1, 0, 1);
        step("ps_tc_width",   1, 0, 3'd0, 1, 0, 3'd0, 0, 0, 1);
        step("ps_done",       1, 0, 3'd0, 1, 0, 3'd0, 0, 0, 1);
`else
        // One-shot from 3
        step("os_load",       1, 1, 3'd3, 1, 0, 3'd3, 0, 1, 0);
        step("os_2",          1, 0, 3'd0, 1, 0, 3'd2, 0, 1, 0);
        step("os_1",          1, 0, 3'd0, 1, 0, 3'd1, 0, 1, 0);
        step("os_tc",         1, 0, 3'd0, 1, 0, 3'd0, 1, 0, 1);
        for (int i = 0; i < 5; i++)
            step("os_hold",   1, 0, 3'd0, 1, 0, 3'd0, 0, 0, 1);

        // Auto-reload from 2
        step("ar_load",       1, 1, 3'd2, 1, 1, 3'd2, 0, 1, 0);
        step("ar_1a",         1, 0, 3'd0, 1, 1, 3'd1, 0, 1, 0);
        step("ar_tc_a",       1, 0, 3'd0, 1, 1, 3'd0, 1, 1, 0);
        step("ar_wrap",       1, 0, 3'd0, 1, 1, 3'd2, 0, 1, 0);
        step("ar_1b",         1, 0, 3'd0, 1, 1, 3'd1, 0, 1, 0);
        step("ar_tc_b",       1, 0, 3'd0, 1, 1, 3'd0, 1, 1, 0);
        step("ar_wrap2",      1, 0, 3'd0, 1, 1, 3'd2, 0, 1, 0);

        // Enable gap, then mid-count reload at count 1
        step("gap_load5",     1, 1, 3'd5, 1, 1, 3'd5, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            step("gap_hold",  1, 0, 3'd0, 0, 1, 3'd5, 0, 1, 0);
        step("gap_4",         1, 0, 3'd0, 1, 1, 3'd4, 0, 1, 0);
        step("gap_3",         1, 0, 3'd0, 1, 1, 3'd3, 0, 1, 0);
        step("gap_2",         1, 0, 3'd0, 1, 1, 3'd2, 0, 1, 0);
        step("gap_1",         1, 0, 3'd0, 1, 1, 3'd1, 0, 1, 0);
        step("midload_6",     1, 1, 3'd6, 1, 1, 3'd6, 0, 1, 0);

        // Zero load goes straight to DONE; en alone stays there
        step("zero_load",     1, 1, 3'd0, 1, 0, 3'd0, 0, 0, 1);
        step("done_en",       1, 0, 3'd0, 1, 0, 3'd0, 0, 0, 1);

        // Reset mid-count, then restart from IDLE via en
        step("rs_load4",      1, 1, 3'd4, 0, 0, 3'd4, 0, 1, 0);
        step("rs_midrun",     0, 0, 3'd0, 1, 0, 3'd7, 0, 0, 0);
        step("idle_en_start", 1, 0, 3'd0, 1, 0, 3'd7, 0, 1, 0);
        step("run_6",         1, 0, 3'd0, 1, 0, 3'd6, 0, 1, 0);
        step("load1_os",      1, 1, 3'd1, 1, 0, 3'd1, 0, 1, 0);
        step("load1_tc",      1, 0, 3'd0, 1, 0, 3'd0, 1, 0, 1);
`endif

        stim_done = 1;
        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_down_counter_ctl
`default_nettype wire
